data_memory: RTL and testbench

- Single-port 256 x 8 synchronous-write data memory for the datapath's load/store stage.
- Word-addressed by an 8-bit address from the ALU result.
- Writes are committed on the rising clock edge. Reads are combinational and gated by memread.
- Asynchronous active-high reset clears the whole array to a known state.

---
 rtl/data_memory_pkg.sv | 14 +
 rtl/data_memory.sv | 51 +++++
 tb/tb_data_memory.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared widths, types and reset fill word for data_memory
package data_memory_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;
    localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
    typedef logic [DATA_W_DEFAULT-1:0] data_t;

    // Word loaded into every location while RESET is held (identity preload aside)
    localparam data_t RESET_WORD = '0;

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - 256x8 sync-write / comb-read data memory; DATA_MEMORY_INIT_EN selects identity preload on reset
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memread,
    input  logic              memwrite,
    output logic [DATA_W-1:0] readdata
);

    localparam int LOC_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [LOC_DEPTH];
    logic [DATA_W-1:0] w_rd_word;

    // Array update: reset fills every word at once; otherwise one write per rising edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < LOC_DEPTH; i++) begin
`ifdef DATA_MEMORY_INIT_EN
                r_mem[i] <= DATA_W'(i);
`else
                r_mem[i] <= DATA_W'(RESET_WORD);
`endif
            end
        end else if (memwrite == 1'b1) begin
            r_mem[address] <= writedata;
        end
    end

    assign w_rd_word = r_mem[address];

    // Read mux: no bypass, so a same-cycle write shows only after the edge
    always_comb begin
        readdata = '0;
        if (memread && !RESET) begin
            readdata = w_rd_word;
        end
    end

    // Control and address must be known whenever a write could be committed
    a_known_ctrl: assert property (@(posedge CLK) disable iff (RESET)
        !$isunknown(memwrite) && !$isunknown(address));

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory against an array reference model
module tb_data_memory;
    import data_memory_pkg::*;

    logic  CLK;
    logic  RESET;
    addr_t address;
    data_t writedata;
    logic  memread;
    logic  memwrite;
    data_t readdata;

    int n_checks = 0;
    int n_fail   = 0;

    data_t model [DEPTH];

    data_memory dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .address   (address),
        .writedata (writedata),
        .memread   (memread),
        .memwrite  (memwrite),
        .readdata  (readdata)
    );

    initial CLK = 1'b0;
    always #25 CLK = ~CLK;

    function automatic data_t reset_value(input int idx);
`ifdef DATA_MEMORY_INIT_EN
        return data_t'(idx);
`else
        return data_t'(0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = reset_value(i);
    endtask

    task automatic do_write(input addr_t a, input data_t d);
        @(negedge CLK);
        address   = a;
        writedata = d;
        memread   = 1'b0;
        memwrite  = 1'b1;
        @(posedge CLK);
        #1;
        memwrite = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset();
        RESET = 1'b1; memread = 1'b1; memwrite = 1'b0; address = 8'h33; writedata = 8'h00;
        model_reset();
        #100;
        n_checks++;
        if (readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold_readdata got=%02h exp=00", readdata);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            address = addr_t'(i);
            #1;
            n_checks++;
            if (readdata !== model[i]) begin
                n_fail++;
                $display("FAIL reset_sweep addr=%02h got=%02h exp=%02h", i, readdata, model[i]);
            end
        end
    endtask

    task automatic test_basic();
        do_write(8'h10, 8'hA5);
        do_write(8'hFF, 8'h3C);
        @(negedge CLK);
        memread = 1'b1; address = 8'h10; #1;
        n_checks++;
        if (readdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_rd_10 got=%02h exp=a5", readdata);
        end
        address = 8'hFF; #1;
        n_checks++;
        if (readdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL basic_rd_ff got=%02h exp=3c", readdata);
        end
    endtask

    task automatic test_read_gating();
        @(negedge CLK);
        address = 8'h10; memread = 1'b0; #1;
        n_checks++;
        if (readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL gate_off got=%02h exp=00", readdata);
        end
        memread = 1'b1; #1;
        n_checks++;
        if (readdata !== model[8'h10]) begin
            n_fail++;
            $display("FAIL gate_on got=%02h exp=%02h", readdata, model[8'h10]);
        end
    endtask

    task automatic test_write_disabled();
        @(negedge CLK);
        address = 8'h10; writedata = 8'h77; memwrite = 1'b0; memread = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (readdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_disabled got=%02h exp=a5", readdata);
        end
    endtask

    task automatic test_same_addr();
        do_write(8'h20, 8'h11);
        @(negedge CLK);
        address = 8'h20; writedata = 8'h22; memread = 1'b1; memwrite = 1'b1; #1;
        n_checks++;
        if (readdata !== 8'h11) begin
            n_fail++;
            $display("FAIL same_addr_before got=%02h exp=11", readdata);
        end
        @(posedge CLK); #1;
        memwrite = 1'b0;
        model[8'h20] = 8'h22;
        n_checks++;
        if (readdata !== 8'h22) begin
            n_fail++;
            $display("FAIL same_addr_after got=%02h exp=22", readdata);
        end
    endtask

    task automatic test_async_reset();
        do_write(8'h05, 8'h5A);
        @(negedge CLK);
        address = 8'h05; memread = 1'b1; #1;
        n_checks++;
        if (readdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL async_pre got=%02h exp=5a", readdata);
        end
        #5;
        RESET = 1'b1; #1;
        model_reset();
        n_checks++;
        if (readdata !== 8'h00) begin
            n_fail++;
            $display("FAIL async_immediate got=%02h exp=00", readdata);
        end
        // attempt a write while reset is held; it must be ignored
        address = 8'h06; writedata = 8'hEE; memwrite = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        memwrite = 1'b0; RESET = 1'b0;
        address = 8'h05; #1;
        n_checks++;
        if (readdata !== reset_value(5)) begin
            n_fail++;
            $display("FAIL async_after_05 got=%02h exp=%02h", readdata, reset_value(5));
        end
        address = 8'h06; #1;
        n_checks++;
        if (readdata !== reset_value(6)) begin
            n_fail++;
            $display("FAIL reset_mid_write_06 got=%02h exp=%02h", readdata, reset_value(6));
        end
    endtask

    task automatic test_random();
        addr_t a;
        data_t d, exp_v;
        logic  we, re;
        for (int n = 0; n < 400; n++) begin
            a  = addr_t'($urandom_range(0, 255));
            if (n % 3 == 0) a = addr_t'($urandom_range(0, 7));
            d  = data_t'($urandom);
            we = 1'($urandom_range(0, 1));
            re = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            address = a; writedata = d; memwrite = we; memread = re; #1;
            exp_v = re ? model[a] : 8'h00;
            n_checks++;
            if (readdata !== exp_v) begin
                n_fail++;
                $display("FAIL rand_pre n=%0d addr=%02h got=%02h exp=%02h", n, a, readdata, exp_v);
            end
            @(posedge CLK); #1;
            if (we) model[a] = d;
            exp_v = re ? model[a] : 8'h00;
            n_checks++;
            if (readdata !== exp_v) begin
                n_fail++;
                $display("FAIL rand_post n=%0d addr=%02h got=%02h exp=%02h", n, a, readdata, exp_v);
            end
        end
        memwrite = 1'b0;
        memread  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            address = addr_t'(i); #1;
            n_checks++;
            if (readdata !== model[i]) begin
                n_fail++;
                $display("FAIL rand_sweep addr=%02h got=%02h exp=%02h", i, readdata, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_read_gating();
        test_write_disabled();
        test_same_addr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
